// File: rtl/cond_unit_ex_pkg.sv
// cond_unit_ex_pkg
// Shared definitions for the Execute-stage condition unit and anything else
// that needs to decode ARM condition fields (e.g. the branch predictor).
//   - COND_* : 4-bit condition field encodings (instr[31:28])
//   - FLAG_* : bit positions of N, Z, C, V inside the 4-bit flag vector
package cond_unit_ex_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_unit_ex_cond_check.sv
// cond_check
// Purely combinational ARM condition evaluator.
// Ports:
//   cond    in  4  condition field
//   flags   in  4  {N,Z,C,V}
//   cond_ex out 1  1 when the condition holds for the given flags
module cond_check
    import cond_unit_ex_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;
    logic base;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Conditions come in complementary pairs: cond[3:1] picks the base test
    // and cond[0] inverts it. The last pair (AL and the unconditional space)
    // is always true and must not be inverted.
    always_comb begin
        base = 1'b1;
        case (cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
    end

    assign cond_ex = (cond[3:1] == 3'd7) ? 1'b1 : (base ^ cond[0]);

endmodule

// File: rtl/cond_unit_ex.sv
// cond_unit_ex
// Execute-stage condition unit. Holds the NZCV flag register, evaluates the
// condition of the instruction in Execute against it, and gates that
// instruction's side effects into the Memory-stage register. Also keeps
// wrap-around executed/squashed counters for performance debug.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   valid_e/stall_e/flush_e  Execute stage qualifiers
//   cond_e, flag_write_e  condition field and flag-pair update enables
//   reg_write_e, mem_write_e, pc_src_e, no_write_e  ungated side effects
//   alu_flags             {N,Z,C,V} from the ALU
//   flags                 registered {N,Z,C,V}
//   cond_ex_e, branch_taken_e  combinational condition result / redirect
//   reg_write_m, mem_write_m, pc_src_m  gated, registered side effects
//   exec_cnt, squash_cnt  event counters
module cond_unit_ex
    import cond_unit_ex_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_e,
    input  logic             stall_e,
    input  logic             flush_e,
    input  logic [3:0]       cond_e,
    input  logic [1:0]       flag_write_e,
    input  logic             reg_write_e,
    input  logic             mem_write_e,
    input  logic             pc_src_e,
    input  logic             no_write_e,
    input  logic [3:0]       alu_flags,
    output logic [3:0]       flags,
    output logic             cond_ex_e,
    output logic             branch_taken_e,
    output logic             reg_write_m,
    output logic             mem_write_m,
    output logic             pc_src_m,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    logic go;
    logic pass;

    // The registered flags are already current for this instruction: the
    // previous one wrote them on the edge that ended its Execute cycle.
    cond_check u_cond_check (
        .cond    (cond_e),
        .flags   (flags),
        .cond_ex (cond_ex_e)
    );

    assign go             = valid_e & ~flush_e & ~stall_e;
    assign pass           = go & cond_ex_e;
    assign branch_taken_e = pass & pc_src_e;

    // Any of stall, flush or bubble drops go, so the Memory stage sees a
    // bubble and neither flags nor counters move.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags       <= 4'b0000;
            reg_write_m <= 1'b0;
            mem_write_m <= 1'b0;
            pc_src_m    <= 1'b0;
            exec_cnt    <= '0;
            squash_cnt  <= '0;
        end else begin
            if (pass && flag_write_e[1]) begin
                flags[FLAG_N] <= alu_flags[FLAG_N];
                flags[FLAG_Z] <= alu_flags[FLAG_Z];
            end
            if (pass && flag_write_e[0]) begin
                flags[FLAG_C] <= alu_flags[FLAG_C];
                flags[FLAG_V] <= alu_flags[FLAG_V];
            end
            reg_write_m <= pass & reg_write_e & ~no_write_e;
            mem_write_m <= pass & mem_write_e;
            pc_src_m    <= pass & pc_src_e;
            if (go) begin
                if (cond_ex_e) begin
                    exec_cnt <= exec_cnt + CNT_W'(1);
                end else begin
                    squash_cnt <= squash_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cond_unit_ex.sv
// tb_cond_unit_ex
// Self-checking bench for cond_unit_ex: a directed vector table, a full
// condition sweep, randomized traffic against a reference model, an
// asynchronous mid-run reset and an event-counter wrap sequence.
module tb_cond_unit_ex;

    localparam int CNT_W = 8;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk;
    logic             reset_n;
    logic             valid_e, stall_e, flush_e;
    logic [3:0]       cond_e;
    logic [1:0]       flag_write_e;
    logic             reg_write_e, mem_write_e, pc_src_e, no_write_e;
    logic [3:0]       alu_flags;
    logic [3:0]       flags;
    logic             cond_ex_e, branch_taken_e;
    logic             reg_write_m, mem_write_m, pc_src_m;
    logic [CNT_W-1:0] exec_cnt, squash_cnt;

    cond_unit_ex #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .valid_e        (valid_e),
        .stall_e        (stall_e),
        .flush_e        (flush_e),
        .cond_e         (cond_e),
        .flag_write_e   (flag_write_e),
        .reg_write_e    (reg_write_e),
        .mem_write_e    (mem_write_e),
        .pc_src_e       (pc_src_e),
        .no_write_e     (no_write_e),
        .alu_flags      (alu_flags),
        .flags          (flags),
        .cond_ex_e      (cond_ex_e),
        .branch_taken_e (branch_taken_e),
        .reg_write_m    (reg_write_m),
        .mem_write_m    (mem_write_m),
        .pc_src_m       (pc_src_m),
        .exec_cnt       (exec_cnt),
        .squash_cnt     (squash_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid, stall, flush;
        logic [3:0] cond;
        logic [1:0] fw;
        logic       rw, mw, pc, nw;
        logic [3:0] alu;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic       exp_cond, exp_br;
        logic [3:0] exp_flags;
        logic       exp_reg, exp_mem, exp_pc;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [3:0] m_flags;
    logic       m_reg, m_mem, m_pc;
    int         m_exec, m_squash;
    stim_t      cur;

    // Condition table written straight from the ARM mnemonic definitions
    function automatic logic refCond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    function automatic stim_t mk(input logic v, input logic st, input logic fl,
                                 input logic [3:0] c, input logic [1:0] fw,
                                 input logic rw, input logic mw, input logic pc,
                                 input logic nw, input logic [3:0] alu);
        stim_t s;
        s.valid = v; s.stall = st; s.flush = fl; s.cond = c; s.fw = fw;
        s.rw = rw; s.mw = mw; s.pc = pc; s.nw = nw; s.alu = alu;
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_flags = 4'b0000;
        m_reg = 1'b0; m_mem = 1'b0; m_pc = 1'b0;
        m_exec = 0; m_squash = 0;
    endtask

    // Drives one instruction and checks the combinational outputs against
    // the model; finishCycle then clocks it and checks the registered ones.
    task automatic applyStimulus(input stim_t s);
        logic ok, br;
        cur = s;
        valid_e = s.valid; stall_e = s.stall; flush_e = s.flush;
        cond_e = s.cond; flag_write_e = s.fw;
        reg_write_e = s.rw; mem_write_e = s.mw; pc_src_e = s.pc;
        no_write_e = s.nw; alu_flags = s.alu;
        #1;
        ok = refCond(s.cond, m_flags);
        br = s.pc && ok && s.valid && !s.flush && !s.stall;
        checkOutput("cond_ex_e", 32'(cond_ex_e), 32'(ok));
        checkOutput("branch_taken_e", 32'(branch_taken_e), 32'(br));
    endtask

    task automatic finishCycle();
        logic issued, ok;
        @(posedge clk);
        issued = cur.valid && !cur.stall && !cur.flush;
        ok = issued && refCond(cur.cond, m_flags);
        if (ok && cur.fw[1]) m_flags[3:2] = cur.alu[3:2];
        if (ok && cur.fw[0]) m_flags[1:0] = cur.alu[1:0];
        m_reg = ok && cur.rw && !cur.nw;
        m_mem = ok && cur.mw;
        m_pc  = ok && cur.pc;
        if (issued && refCond(cur.cond, 4'(0)) == refCond(cur.cond, 4'(0))) begin
            if (ok) m_exec = (m_exec + 1) % CNT_MOD;
            else    m_squash = (m_squash + 1) % CNT_MOD;
        end
        #1;
        checkOutput("flags", 32'(flags), 32'(m_flags));
        checkOutput("reg_write_m", 32'(reg_write_m), 32'(m_reg));
        checkOutput("mem_write_m", 32'(mem_write_m), 32'(m_mem));
        checkOutput("pc_src_m", 32'(pc_src_m), 32'(m_pc));
        checkOutput("exec_cnt", 32'(exec_cnt), 32'(m_exec));
        checkOutput("squash_cnt", 32'(squash_cnt), 32'(m_squash));
    endtask

    task automatic checkAllClear(input string tag);
        checkOutput({tag, " flags"}, 32'(flags), 32'd0);
        checkOutput({tag, " reg_write_m"}, 32'(reg_write_m), 32'd0);
        checkOutput({tag, " mem_write_m"}, 32'(mem_write_m), 32'd0);
        checkOutput({tag, " pc_src_m"}, 32'(pc_src_m), 32'd0);
        checkOutput({tag, " exec_cnt"}, 32'(exec_cnt), 32'd0);
        checkOutput({tag, " squash_cnt"}, 32'(squash_cnt), 32'd0);
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        valid_e = 0; stall_e = 0; flush_e = 0; cond_e = 4'hE; flag_write_e = 2'b00;
        reg_write_e = 0; mem_write_e = 0; pc_src_e = 0; no_write_e = 0; alu_flags = 4'h0;
        cur = mk(0, 0, 0, 4'hE, 2'b00, 0, 0, 0, 0, 4'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[11];

    initial begin
        // Directed table: expectations worked out by hand from the decode
        // rules, starting from the post-reset state (flags 0000).
        vecs[0]  = '{mk(1,0,0,4'hE,2'b11,1,0,0,0,4'b0110), 1, 0, 4'b0110, 1, 0, 0};
        vecs[1]  = '{mk(1,0,0,4'h0,2'b00,0,0,1,0,4'b0000), 1, 1, 4'b0110, 0, 0, 1};
        vecs[2]  = '{mk(1,0,0,4'hE,2'b11,0,0,0,0,4'b1000), 1, 0, 4'b1000, 0, 0, 0};
        vecs[3]  = '{mk(1,0,0,4'hE,2'b10,1,0,0,0,4'b0011), 1, 0, 4'b0000, 1, 0, 0};
        vecs[4]  = '{mk(1,0,0,4'h0,2'b11,1,0,0,0,4'b1111), 0, 0, 4'b0000, 0, 0, 0};
        vecs[5]  = '{mk(1,0,0,4'hE,2'b11,1,0,0,1,4'b0010), 1, 0, 4'b0010, 0, 0, 0};
        vecs[6]  = '{mk(1,1,0,4'hE,2'b11,1,1,1,0,4'b1111), 1, 0, 4'b0010, 0, 0, 0};
        vecs[7]  = '{mk(1,0,1,4'hE,2'b11,1,1,1,0,4'b1111), 1, 0, 4'b0010, 0, 0, 0};
        vecs[8]  = '{mk(1,1,1,4'hE,2'b11,1,1,1,0,4'b1111), 1, 0, 4'b0010, 0, 0, 0};
        vecs[9]  = '{mk(0,0,0,4'hE,2'b11,1,1,1,0,4'b1111), 1, 0, 4'b0010, 0, 0, 0};
        vecs[10] = '{mk(1,0,0,4'h1,2'b00,0,1,0,0,4'b1111), 1, 0, 4'b0010, 0, 1, 0};

        doReset();
        checkAllClear("reset");

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].s);
            checkOutput($sformatf("tbl%0d cond_ex_e", i), 32'(cond_ex_e), 32'(vecs[i].exp_cond));
            checkOutput($sformatf("tbl%0d branch_taken_e", i), 32'(branch_taken_e), 32'(vecs[i].exp_br));
            finishCycle();
            checkOutput($sformatf("tbl%0d flags", i), 32'(flags), 32'(vecs[i].exp_flags));
            checkOutput($sformatf("tbl%0d reg_write_m", i), 32'(reg_write_m), 32'(vecs[i].exp_reg));
            checkOutput($sformatf("tbl%0d mem_write_m", i), 32'(mem_write_m), 32'(vecs[i].exp_mem));
            checkOutput($sformatf("tbl%0d pc_src_m", i), 32'(pc_src_m), 32'(vecs[i].exp_pc));
        end
        // Six passing instructions issued, one squashed
        checkOutput("tbl exec_cnt", 32'(exec_cnt), 32'd6);
        checkOutput("tbl squash_cnt", 32'(squash_cnt), 32'd1);

        // Condition sweep: load each flag value, then try all 16 conditions
        for (int f = 0; f < 16; f++) begin
            applyStimulus(mk(1,0,0,4'hE,2'b11,0,0,0,0,4'(f)));
            finishCycle();
            for (int c = 0; c < 16; c++) begin
                applyStimulus(mk(0,0,0,4'(c),2'b00,0,0,0,0,4'h0));
            end
            finishCycle();
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            stim_t s;
            s = mk($urandom_range(0,99) < 80, $urandom_range(0,99) < 10,
                   $urandom_range(0,99) < 10, 4'($urandom_range(0,15)),
                   2'($urandom_range(0,3)), 1'($urandom_range(0,1)),
                   1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
                   $urandom_range(0,99) < 20, 4'($urandom_range(0,15)));
            applyStimulus(s);
            finishCycle();
        end

        // Asynchronous reset mid-cycle: outputs must clear before any edge
        applyStimulus(mk(1,0,0,4'hE,2'b11,1,1,1,0,4'b1111));
        finishCycle();
        #2;
        reset_n = 1'b0;
        #1;
        checkAllClear("async reset");
        modelReset();
        doReset();
        checkAllClear("after async reset");

        // Counter wrap: 255 passing ops reach all-ones, one more wraps to 0
        for (int i = 0; i < CNT_MOD - 1; i++) begin
            applyStimulus(mk(1,0,0,4'hE,2'b00,0,0,0,0,4'h0));
            finishCycle();
        end
        checkOutput("exec_cnt all-ones", 32'(exec_cnt), 32'(CNT_MOD - 1));
        applyStimulus(mk(1,0,0,4'hE,2'b00,0,0,0,0,4'h0));
        finishCycle();
        checkOutput("exec_cnt wrapped", 32'(exec_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cond_unit_ex.md
Name: cond_unit_ex

Overview:
- Execute-stage condition unit, directly downstream of the ALU.
- Holds the architectural NZCV flag register and updates it from the ALU flag vector.
- Evaluates the 4-bit ARM condition field of the instruction in Execute and gates that instruction's side effects (register write, memory write, PC redirect) into the Memory-stage pipeline register.
- Keeps wrap-around counters of executed and condition-squashed instructions for performance debug.

Parameters:
- CNT_W, 32, width of the executed/squashed event counters.

Ports:
- clk  in  1  core clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- valid_e  in  1  Execute stage holds a real instruction (0 = bubble)
- stall_e  in  1  Execute stage frozen this cycle
- flush_e  in  1  instruction in Execute is killed (mispredict/exception)
- cond_e  in  4  condition field, instr[31:28]
- flag_write_e  in  2  [1] enables N,Z update; [0] enables C,V update
- reg_write_e  in  1  instruction writes the register file
- mem_write_e  in  1  instruction writes memory
- pc_src_e  in  1  instruction redirects the PC (branch or write to R15)
- no_write_e  in  1  compare-class op (CMP/CMN/TST/TEQ): suppress register write
- alu_flags  in  4  {N,Z,C,V} from the ALU for the instruction in Execute
- flags  out  4  current registered {N,Z,C,V}
- cond_ex_e  out  1  combinational: condition passes against `flags`
- branch_taken_e  out  1  combinational: pc_src_e & cond_ex_e & valid_e & ~flush_e & ~stall_e
- reg_write_m  out  1  registered, gated register-write enable for Memory stage
- mem_write_m  out  1  registered, gated memory-write enable for Memory stage
- pc_src_m  out  1  registered, gated PC-source for Memory stage
- exec_cnt  out  CNT_W  count of instructions that passed their condition
- squash_cnt  out  CNT_W  count of instructions that failed their condition

Behaviour:
- Reset (reset_n low, asynchronous): flags=4'b0000, reg_write_m=mem_write_m=pc_src_m=0, both counters=0. Reset applies mid-operation regardless of stall/flush.
- Condition decode uses the registered `flags`, which is correct because the preceding instruction updated them on the edge that ended its Execute cycle; no forwarding.
- EQ 0:Z; NE 1:~Z; CS 2:C; CC 3:~C; MI 4:N; PL 5:~N; VS 6:V; VC 7:~V.
- HI 8:C&~Z; LS 9:~C|Z; GE A:N==V; LT B:N!=V; GT C:~Z&(N==V); LE D:Z|(N!=V); AL E:1; F (unconditional space):1.
- Define go = valid_e & ~flush_e & ~stall_e. Define pass = go & cond_ex_e.
- Flag update on the rising edge:
  - if pass & flag_write_e[1]: flags[3:2] <= alu_flags[3:2]
  - if pass & flag_write_e[0]: flags[1:0] <= alu_flags[1:0]
  - otherwise each flag pair holds.
- Memory-stage register, one cycle latency:
  - reg_write_m <= pass & reg_write_e & ~no_write_e
  - mem_write_m <= pass & mem_write_e
  - pc_src_m <= pass & pc_src_e
  - When stall_e or flush_e is high, or valid_e is low, all three load 0 (bubble inserted).
- Counters, evaluated on the rising edge only when go:
  - exec_cnt += 1 if cond_ex_e
  - squash_cnt += 1 if ~cond_ex_e
  - Both wrap from all-ones to 0 silently; no saturation.
- Simultaneous stall_e and flush_e: flush_e wins for side effects. Both already yield a bubble with no flag or counter update.
- A compare-class op with a failing condition updates neither flags nor the register file.

Decomposition:
- Shared package: cond-code localparams COND_EQ..COND_AL, COND_NV; flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One sub-module, cond_check: purely combinational (cond[3:0], flags[3:0]) -> cond_ex. Reusable by the branch predictor.

Test Plan:
- Reset: hold reset_n=0, then release -> flags=0000, all *_m=0, exec_cnt=squash_cnt=0. Assert reset_n=0 asynchronously mid-run -> outputs clear without waiting for a clk edge.
- SUBS sets Z: cond_e=E, flag_write_e=11, alu_flags=0110, valid -> next cycle flags=0110. Then BEQ with cond_e=0, pc_src_e=1 -> branch_taken_e=1, pc_src_m=1 one cycle later.
- Partial update: flags=1000; ADDS-like op with flag_write_e=10, alu_flags=0011 -> flags=0000 (N,Z from ALU; C,V held at 00).
- Condition fail: flags=0000, cond_e=0 (EQ), reg_write_e=1, flag_write_e=11, alu_flags=1111 -> reg_write_m=0, flags stay 0000, squash_cnt +1.
- CMP: cond_e=E, no_write_e=1, reg_write_e=1, flag_write_e=11, alu_flags=0010 -> reg_write_m=0, flags=0010, exec_cnt +1.
- Stall/flush/wrap:
  - stall_e=1 with a passing ADDS -> flags unchanged, all *_m=0, counters unchanged.
  - Same instruction with flush_e=1 -> identical response.
  - Preload exec_cnt=all-ones, one passing op -> exec_cnt=0.
- Cond sweep: all 16 cond_e values against all 16 flags values -> cond_ex_e matches the decode table exactly (256 checks).
